// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step is done per clock.
module hilo_mdu #(
    parameter int DATA_W    = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic              cancel_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_by_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   opd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic                div_q;
    logic                dbz_q;

    logic busy_d, done_d, dbz_d, load_hilo, write_hi, write_lo;

    // Request decode; all of it is only meaningful while IDLE.
    logic              is_mul, is_div, signed_op, sign_a, sign_b, opb_zero, accept;
    logic [DATA_W-1:0] mag_a, mag_b;

    assign is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign signed_op = SIGNED_EN && !op_i[0];
    assign sign_a    = signed_op && opa_i[DATA_W-1];
    assign sign_b    = signed_op && opb_i[DATA_W-1];
    assign mag_a     = sign_a ? -opa_i : opa_i;
    assign mag_b     = sign_b ? -opb_i : opb_i;
    assign opb_zero  = (opb_i == '0);
    assign accept    = (state_q == S_IDLE) && start_i && !cancel_i;

    logic last_iter;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    // Multiply step: add the multiplicand into the upper half when the low bit is set, then shift right.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opd_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]}
                               : {1'b0, acc_q[2*DATA_W-1:1]};

    // Divide step: shift the next dividend bit into the remainder, subtract when it fits.
    logic [DATA_W:0]     div_rem_shift, div_diff;
    logic [2*DATA_W-1:0] div_step;
    assign div_rem_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_diff      = div_rem_shift - {1'b0, opd_q};
    assign div_step      = !div_diff[DATA_W]
                           ? {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                           : {div_rem_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

    // State register plus the registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            div_by_zero_o <= dbz_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul)
                    state_d = S_MUL;
                else if (accept && is_div)
                    state_d = opb_zero ? S_DONE : S_DIV;
            end
            S_MUL, S_DIV: begin
                if (cancel_i)
                    state_d = S_IDLE;
                else if (last_iter)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and HI/LO write enables.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_q == S_DONE) && !cancel_i;
        load_hilo = done_d && !dbz_q;
        dbz_d     = done_d && dbz_q;
        write_hi  = accept && (op_i == OP_MTHI);
        write_lo  = accept && (op_i == OP_MTLO);
    end

    // Datapath: operand latch at acceptance, then one iteration per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (accept && (is_mul || is_div)) begin
            acc_q    <= {{DATA_W{1'b0}}, (is_mul ? mag_b : mag_a)};
            opd_q    <= is_mul ? mag_a : mag_b;
            cnt_q    <= '0;
            neg_lo_q <= sign_a ^ sign_b;
            neg_hi_q <= sign_a;
            div_q    <= is_div;
            dbz_q    <= is_div && opb_zero;
        end else if (state_q == S_MUL) begin
            acc_q <= mul_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (state_q == S_DIV) begin
            acc_q <= div_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Final sign correction; most-negative / -1 wraps naturally in the negation.
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, hi_res, lo_res;
    always_comb begin
        prod = neg_lo_q ? -acc_q : acc_q;
        quo  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        if (div_q) begin
            hi_res = rem;
            lo_res = quo;
        end else begin
            hi_res = prod[2*DATA_W-1:DATA_W];
            lo_res = prod[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (load_hilo) begin
            hi_o <= hi_res;
            lo_o <= lo_res;
        end else begin
            if (write_hi) hi_o <= opa_i;
            if (write_lo) lo_o <= opa_i;
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: a scoreboard of expected HI/LO results
// popped whenever the unit signals completion.
module tb_hilo_mdu;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] opa_i = '0;
    logic [W-1:0] opb_i = '0;
    logic         cancel_i = 1'b0;
    logic         busy_o, done_o, div_by_zero_o;
    logic [W-1:0] hi_o, lo_o;

    hilo_mdu #(.DATA_W(W), .SIGNED_EN(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .opa_i         (opa_i),
        .opb_i         (opb_i),
        .cancel_i      (cancel_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        string        tag;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] arch_hi = '0;
    logic [W-1:0] arch_lo = '0;
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           unexpected = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.hi  = arch_hi;
        e.lo  = arch_lo;
        e.dbz = 1'b0;
        e.tag = "";
        case (op)
            OP_MULT: begin
                p    = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p    = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_DIV: begin
                if (b == '0) e.dbz = 1'b1;
                else begin
                    p    = 64'(sa / sb);
                    e.lo = p[31:0];
                    p    = 64'(sa % sb);
                    e.hi = p[31:0];
                end
            end
            default: begin
                if (b == '0) e.dbz = 1'b1;
                else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            done_cnt++;
            if (sb_q.size() == 0) unexpected++;
            else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, "_hi"},  64'(hi_o), 64'(e.hi));
                check({e.tag, "_lo"},  64'(lo_o), 64'(e.lo));
                check({e.tag, "_dbz"}, 64'(div_by_zero_o), 64'(e.dbz));
                arch_hi = e.hi;
                arch_lo = e.lo;
            end
        end else if (!rst && div_by_zero_o) begin
            unexpected++;
        end
    end

    // Called at posedge+1; start is sampled at the next edge (E0), returns at E0+1.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        exp_t e;
        e     = model(op, a, b);
        e.tag = tag;
        sb_q.push_back(e);
        start_i = 1'b1;
        op_i    = op;
        opa_i   = a;
        opb_i   = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i    = 3'($urandom);
        opa_i   = $urandom;
        opb_i   = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        int bc  = 0;
        while (!done_o && lat < 60) begin
            if (busy_o) bc++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        check({tag, "_busy_fall"}, 64'(busy_o), 64'(0));
        @(posedge clk); #1;
        check({tag, "_done_single"}, 64'(done_o), 64'(0));
    endtask

    task automatic move_to(input logic [2:0] op, input logic [W-1:0] val, input string tag);
        start_i = 1'b1;
        op_i    = op;
        opa_i   = val;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (op == OP_MTHI) arch_hi = val;
        else arch_lo = val;
        check({tag, "_hi"}, 64'(hi_o), 64'(arch_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(arch_lo));
        check({tag, "_busy"}, 64'(busy_o), 64'(0));
        check({tag, "_done"}, 64'(done_o), 64'(0));
    endtask

    initial begin
        int base;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        #12;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_dbz",  64'(div_by_zero_o), 64'(0));
        check("rst_hi",   64'(hi_o), 64'(0));
        check("rst_lo",   64'(lo_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // First request right after reset release must be taken at the first edge.
        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2");
        check("mult_busy_e0", 64'(busy_o), 64'(1));
        wait_done("mult_neg1x2", 33);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        wait_done("multu_max", 33);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
        wait_done("div_m7_2", 33);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
        wait_done("div_wrap", 33);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
        wait_done("mult_minmin", 33);
        issue(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, "div_7_m2");
        wait_done("div_7_m2", 33);

        // Divide by zero: no iteration, HI/LO untouched.
        issue(OP_DIVU, 32'h1234_5678, 32'h0000_0000, "divu_zero");
        wait_done("divu_zero", 1);
        issue(OP_DIV, 32'h8765_4321, 32'h0000_0000, "div_zero");
        wait_done("div_zero", 1);

        move_to(OP_MTHI, 32'h1234_5678, "mthi");
        move_to(OP_MTLO, 32'h9ABC_DEF0, "mtlo");

        // MTHI while a multiply runs must not touch HI.
        issue(OP_MULTU, 32'h0001_0003, 32'h0000_1005, "multu_mid_mthi");
        repeat (5) @(posedge clk);
        #1;
        start_i = 1'b1;
        op_i    = OP_MTHI;
        opa_i   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("mid_mthi_hi", 64'(hi_o), 64'(arch_hi));
        check("mid_mthi_busy", 64'(busy_o), 64'(1));
        wait_done("multu_mid_mthi", 27);

        // Cancel at iteration 10 of DIVU, then a fresh MULTU the next cycle.
        base = done_cnt;
        issue(OP_DIVU, 32'hFFFF_0000, 32'h0000_0013, "divu_cancel");
        repeat (10) @(posedge clk);
        #1;
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        void'(sb_q.pop_back());
        check("cancel_busy", 64'(busy_o), 64'(0));
        check("cancel_hi", 64'(hi_o), 64'(arch_hi));
        check("cancel_lo", 64'(lo_o), 64'(arch_lo));
        issue(OP_MULTU, 32'h0000_ABCD, 32'h0001_0001, "multu_after_cancel");
        check("cancel_no_done", 64'(done_cnt - base), 64'(0));
        wait_done("multu_after_cancel", 33);

        // Cancel while in DONE drops the result.
        base = done_cnt;
        issue(OP_MULT, 32'h0000_0003, 32'hFFFF_FFFB, "mult_cancel_done");
        repeat (32) @(posedge clk);
        #1;
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        check("cdone_busy", 64'(busy_o), 64'(0));
        check("cdone_hi", 64'(hi_o), 64'(arch_hi));
        check("cdone_no_done", 64'(done_cnt - base), 64'(0));

        // Cancel together with start in IDLE, and an undefined opcode.
        start_i  = 1'b1;
        cancel_i = 1'b1;
        op_i     = OP_MTHI;
        opa_i    = 32'h5555_AAAA;
        @(posedge clk); #1;
        op_i     = OP_MULTU;
        check("idle_cancel_mthi", 64'(hi_o), 64'(arch_hi));
        @(posedge clk); #1;
        check("idle_cancel_mult", 64'(busy_o), 64'(0));
        cancel_i = 1'b0;
        op_i     = 3'b110;
        @(posedge clk); #1;
        op_i     = 3'b111;
        @(posedge clk); #1;
        start_i  = 1'b0;
        check("undef_busy", 64'(busy_o), 64'(0));
        check("undef_hi", 64'(hi_o), 64'(arch_hi));
        check("undef_lo", 64'(lo_o), 64'(arch_lo));

        // Asynchronous reset in the middle of a divide.
        base = done_cnt;
        issue(OP_DIV, 32'h7FFF_FFFF, 32'h0000_0005, "div_reset");
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy_o), 64'(0));
        check("arst_hi", 64'(hi_o), 64'(0));
        check("arst_lo", 64'(lo_o), 64'(0));
        #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        arch_hi = '0;
        arch_lo = '0;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_done", 64'(done_cnt - base), 64'(0));

        // A few random operations through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 2) ? 32'($urandom_range(0, 9)) : $urandom;
            issue(rop, ra, rb, $sformatf("rand%0d", i));
            wait_done($sformatf("rand%0d", i), (rop[1] && rb == '0) ? 1 : 33);
        end

        check("unexpected_done", 64'(unexpected), 64'(0));
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
